upsample_stream: RTL and testbench

//  Decoder-side counterpart of the pooled CNN layer path: converts a level-LEVEL feature-map stream into a level-(LEVEL-1) stream.

---
 rtl/upsample_stream.sv | 129 ++++++++++++
 tb/tb_upsample_stream.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/upsample_stream.sv
// upsample_stream: 2x unpooling of a level-LEVEL raster stream to level LEVEL-1.
// Define UPSAMPLE_ZERO_FILL_EN for max-unpool zero insertion instead of replication.
module upsample_stream #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int W_WIDTH    = 400,
    parameter int W_HEIGHT   = 250,
    parameter int FIXED_BITW = 10,
    parameter int UNITS      = 8,
    parameter int LEVEL      = 1,
    localparam int H_BITW    = $clog2(W_WIDTH),
    localparam int V_BITW    = $clog2(W_HEIGHT),
    localparam int PW        = FIXED_BITW * UNITS
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic              in_enable,
    input  logic [PW-1:0]     in_pixels,
    input  logic [V_BITW-1:0] in_vcnt,
    input  logic [H_BITW-1:0] in_hcnt,
    output logic              out_enable,
    output logic [PW-1:0]     out_pixels,
    output logic [V_BITW-1:0] out_vcnt,
    output logic [H_BITW-1:0] out_hcnt
);
    if (LEVEL < 1 || (WIDTH >> LEVEL) < 1 || (HEIGHT >> LEVEL) < 1) begin : g_bad_cfg
        $error("upsample_stream: LEVEL/WIDTH/HEIGHT out of range");
    end

    localparam logic [H_BITW-1:0] HM_S = H_BITW'((1 << LEVEL) - 1);
    localparam logic [V_BITW-1:0] VM_S = V_BITW'((1 << LEVEL) - 1);
    localparam logic [H_BITW-1:0] HM_D = H_BITW'((1 << (LEVEL - 1)) - 1);
    localparam logic [V_BITW-1:0] VM_D = V_BITW'((1 << (LEVEL - 1)) - 1);

    typedef enum logic {WAIT_SOF, RUN} state_t;

    state_t            state_q;
    logic              sof, run, src, dst;
    logic              en1_q, en2_q;
    logic [PW-1:0]     pix1_d, pix1_q, pix2_d, pix2_q;
    logic [V_BITW-1:0] v1_q, v2_q;
    logic [H_BITW-1:0] h1_q, h2_q;

    assign sof = (in_vcnt == '0) && (in_hcnt == '0);
    assign run = (state_q == RUN) || sof;
    assign src = in_enable && ((in_hcnt & HM_S) == '0)
                           && ((in_vcnt & VM_S) == '0);
    assign dst = in_enable && ((in_hcnt & HM_D) == '0)
                           && ((in_vcnt & VM_D) == '0);

    always_ff @(posedge clock) begin
        if (!n_rst) begin
            state_q <= WAIT_SOF;
        end else if (sof) begin
            state_q <= RUN;
        end
    end

`ifdef UPSAMPLE_ZERO_FILL_EN
    assign pix1_d = src ? in_pixels : '0;
    assign pix2_d = pix1_q;
`else
    localparam int DEPTH = WIDTH >> LEVEL;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [H_BITW-1:0] COL_MAX = H_BITW'(DEPTH - 1);

    logic [PW-1:0]     mem [DEPTH];
    logic [PW-1:0]     hold_q, rd_q;
    logic [H_BITW-1:0] col;
    logic [AW-1:0]     addr;
    logic              odd, odd1_q;

    assign odd  = in_vcnt[LEVEL-1];
    assign col  = in_hcnt >> LEVEL;
    // Partial right-hand block folds onto the last buffer entry
    assign addr = (col > COL_MAX) ? COL_MAX[AW-1:0] : col[AW-1:0];

    always_ff @(posedge clock) begin
        if (src) begin
            mem[addr] <= in_pixels;
        end
        if (odd) begin
            rd_q <= mem[addr];
        end
    end

    always_ff @(posedge clock) begin
        if (!n_rst) begin
            hold_q <= '0;
            odd1_q <= 1'b0;
        end else begin
            if (src) begin
                hold_q <= in_pixels;
            end
            odd1_q <= odd;
        end
    end

    assign pix1_d = src ? in_pixels : hold_q;
    assign pix2_d = odd1_q ? rd_q : pix1_q;
`endif

    always_ff @(posedge clock) begin
        if (!n_rst) begin
            en1_q  <= 1'b0;
            pix1_q <= '0;
            v1_q   <= '0;
            h1_q   <= '0;
            en2_q  <= 1'b0;
            pix2_q <= '0;
            v2_q   <= '0;
            h2_q   <= '0;
        end else begin
            en1_q  <= dst && run;
            pix1_q <= pix1_d;
            v1_q   <= in_vcnt;
            h1_q   <= in_hcnt;
            en2_q  <= en1_q;
            pix2_q <= en1_q ? pix2_d : '0;
            v2_q   <= v1_q;
            h2_q   <= h1_q;
        end
    end

    assign out_enable = en2_q;
    assign out_pixels = pix2_q;
    assign out_vcnt   = v2_q;
    assign out_hcnt   = h2_q;
endmodule

// File: tb/tb_upsample_stream.sv
// tb_upsample_stream: raster-driven bench for a LEVEL=2 and a LEVEL=1/WIDTH=15 instance.
// Expected outputs come from a cycle model of the two-stage pipeline plus a spot table.
module tb_upsample_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst, en_a, en_b;
    logic [15:0] pix_a, pix_b;
    logic [3:0]  vc;
    logic [4:0]  hc;
    logic        oe_a, oe_b;
    logic [15:0] op_a, op_b;
    logic [3:0]  ov_a, ov_b;
    logic [4:0]  oh_a, oh_b;

    upsample_stream #(
        .WIDTH(16), .HEIGHT(8), .W_WIDTH(20), .W_HEIGHT(10),
        .FIXED_BITW(8), .UNITS(2), .LEVEL(2)
    ) dut (
        .clock(clk), .n_rst(n_rst), .in_enable(en_a), .in_pixels(pix_a),
        .in_vcnt(vc), .in_hcnt(hc), .out_enable(oe_a), .out_pixels(op_a),
        .out_vcnt(ov_a), .out_hcnt(oh_a)
    );

    upsample_stream #(
        .WIDTH(15), .HEIGHT(8), .W_WIDTH(20), .W_HEIGHT(10),
        .FIXED_BITW(8), .UNITS(2), .LEVEL(1)
    ) dut_b (
        .clock(clk), .n_rst(n_rst), .in_enable(en_b), .in_pixels(pix_b),
        .in_vcnt(vc), .in_hcnt(hc), .out_enable(oe_b), .out_pixels(op_b),
        .out_vcnt(ov_b), .out_hcnt(oh_b)
    );

    typedef struct {
        logic        en;
        logic [15:0] pix;
        int          v;
        int          h;
        int          fr;
        logic        chk;
    } exp_t;

    typedef struct {
        int          v;
        int          h;
        logic        en;
        logic [15:0] nn;
        logic [15:0] zf;
    } vec_t;

`ifdef UPSAMPLE_ZERO_FILL_EN
    localparam int NZ_EXP = 1;
`else
    localparam int NZ_EXP = 4;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cv = 7, ch = 0, fi = 0, pat = 0, kcyc = 0;
    bit run_m = 0;
    int pulses = 0, nz_cnt = 0;
    exp_t a1, a2, b1, b2;
    vec_t tbl [14];
    logic        cap_en  [10][20];
    logic [15:0] cap_pix [10][20];

    function automatic exp_t zero_e();
        exp_t e;
        e.en = 1'b0; e.pix = 16'h0; e.v = 0; e.h = 0; e.fr = -1; e.chk = 1'b1;
        return e;
    endfunction

    function automatic logic [15:0] pat_val(int p, int v, int h);
        logic [7:0] hi, lo;
        if (p == 0) begin
            hi = 8'(16 * (v >> 2) + (h >> 2));
            lo = 8'(-(h >> 2));
            return {hi, lo};
        end
        return ((v >> 2) == 0 && (h >> 2) == 1) ? 16'h005A : 16'h0000;
    endfunction

    function automatic logic [15:0] exp_a(int p, int v, int h);
`ifdef UPSAMPLE_ZERO_FILL_EN
        return (v % 4 == 0 && h % 4 == 0) ? pat_val(p, v, h) : 16'h0;
`else
        return pat_val(p, v, h);
`endif
    endfunction

    function automatic logic [15:0] exp_b(int v, int h);
`ifdef UPSAMPLE_ZERO_FILL_EN
        return (v % 2 == 0 && h % 2 == 0) ? {8'(v), 8'(h)} : 16'h0;
`else
        return {8'(v & ~1), 8'(h & ~1)};
`endif
    endfunction

    task automatic chk(input string nm, input int v, input int h,
                       input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at v=%0d h=%0d: got %h want %h", nm, v, h, got, exp);
        end
    endtask

    task automatic step();
        bit   sof, rst_on, act_a, act_b, sa, da, sb, qual;
        exp_t na, nb;
        sof = (cv == 0 && ch == 0);
        if (sof) begin
            fi++;
            pat = (fi == 2) ? 1 : 0;
        end
        rst_on = (kcyc < 3) || (fi == 3 && cv == 5 && ch < 3);
        act_a = cv < 8 && ch < 16;
        act_b = cv < 8 && ch < 15;
        sa = act_a && cv % 4 == 0 && ch % 4 == 0;
        da = act_a && cv % 2 == 0 && ch % 2 == 0;
        sb = act_b && cv % 2 == 0 && ch % 2 == 0;
        n_rst = !rst_on;
        vc    = 4'(cv);
        hc    = 5'(ch);
        en_a  = act_a;
        en_b  = act_b;
        pix_a = sa ? pat_val(pat, cv, ch) : 16'hC3A5;
        pix_b = sb ? {8'(cv), 8'(ch)} : 16'h7E81;
        qual  = !rst_on && (run_m || sof);
        na.en = qual && da;
        na.pix = na.en ? exp_a(pat, cv, ch) : 16'h0;
        na.v = cv; na.h = ch; na.fr = fi; na.chk = 1'b1;
        nb.en = qual && act_b;
        nb.pix = nb.en ? exp_b(cv, ch) : 16'h0;
        nb.v = cv; nb.h = ch; nb.fr = fi;
        nb.chk = !(cv % 2 == 1 && (ch == 12 || ch == 13));
        @(posedge clk);
        if (rst_on) begin
            run_m = 0;
            a1 = zero_e(); a2 = zero_e(); b1 = zero_e(); b2 = zero_e();
        end else begin
            run_m = run_m || sof;
            a2 = a1; a1 = na; b2 = b1; b1 = nb;
        end
        #1;
        chk("a_enable", a2.v, a2.h, 16'(oe_a), 16'(a2.en));
        chk("a_pixels", a2.v, a2.h, op_a, a2.pix);
        chk("a_vcnt", a2.v, a2.h, 16'(ov_a), 16'(a2.v));
        chk("a_hcnt", a2.v, a2.h, 16'(oh_a), 16'(a2.h));
        chk("b_enable", b2.v, b2.h, 16'(oe_b), 16'(b2.en));
        if (b2.chk) chk("b_pixels", b2.v, b2.h, op_b, b2.pix);
        if (a2.fr == 1) begin
            cap_en[a2.v][a2.h]  = oe_a;
            cap_pix[a2.v][a2.h] = op_a;
            if (oe_a) pulses++;
        end
        if (a2.fr == 2 && op_a != 16'h0) nz_cnt++;
        ch++;
        if (ch == 20) begin
            ch = 0;
            cv++;
            if (cv == 10) cv = 0;
        end
        kcyc++;
    endtask

    initial begin
        tbl[0]  = '{0,  0,  1'b1, 16'h0000, 16'h0000};
        tbl[1]  = '{0,  2,  1'b1, 16'h0000, 16'h0000};
        tbl[2]  = '{2,  0,  1'b1, 16'h0000, 16'h0000};
        tbl[3]  = '{0,  4,  1'b1, 16'h01FF, 16'h01FF};
        tbl[4]  = '{2,  6,  1'b1, 16'h01FF, 16'h0000};
        tbl[5]  = '{4,  8,  1'b1, 16'h12FE, 16'h12FE};
        tbl[6]  = '{6,  10, 1'b1, 16'h12FE, 16'h0000};
        tbl[7]  = '{4,  12, 1'b1, 16'h13FD, 16'h13FD};
        tbl[8]  = '{6,  14, 1'b1, 16'h13FD, 16'h0000};
        tbl[9]  = '{1,  4,  1'b0, 16'h0000, 16'h0000};
        tbl[10] = '{5,  6,  1'b0, 16'h0000, 16'h0000};
        tbl[11] = '{4,  3,  1'b0, 16'h0000, 16'h0000};
        tbl[12] = '{0,  16, 1'b0, 16'h0000, 16'h0000};
        tbl[13] = '{8,  0,  1'b0, 16'h0000, 16'h0000};
        for (int v = 0; v < 10; v++) begin
            for (int h = 0; h < 20; h++) begin
                cap_en[v][h]  = 1'b1;
                cap_pix[v][h] = 16'hDEAD;
            end
        end
        a1 = zero_e(); a2 = zero_e(); b1 = zero_e(); b2 = zero_e();
        n_rst = 1'b0; en_a = 1'b0; en_b = 1'b0;
        pix_a = '0; pix_b = '0; vc = '0; hc = '0;

        for (int k = 0; k < 60 + 4 * 200 + 2; k++) step();

        for (int i = 0; i < 14; i++) begin
`ifdef UPSAMPLE_ZERO_FILL_EN
            chk("tbl_pixels", tbl[i].v, tbl[i].h,
                cap_pix[tbl[i].v][tbl[i].h], tbl[i].zf);
`else
            chk("tbl_pixels", tbl[i].v, tbl[i].h,
                cap_pix[tbl[i].v][tbl[i].h], tbl[i].nn);
`endif
            chk("tbl_enable", tbl[i].v, tbl[i].h,
                16'(cap_en[tbl[i].v][tbl[i].h]), 16'(tbl[i].en));
        end
        chk("frame_pulses", 0, 0, 16'(pulses), 16'd32);
        chk("single_pixel_hits", 0, 0, 16'(nz_cnt), 16'(NZ_EXP));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
